// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the phase sequencer: the byte width, the default
// shared-memory address width and the state encoding of the frame sequencer.
// No ports (package).
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int BYTE_W         = 8;
    localparam int ADDR_W_DEFAULT = 18;
    localparam int STATE_W        = 3;

    // Frame phases in the order a frame walks through them. Plain constants
    // keep the encoding readable from older tools and waveform viewers.
    localparam logic [2:0] ST_RX       = 3'd0;
    localparam logic [2:0] ST_PSTART   = 3'd1;
    localparam logic [2:0] ST_PROC     = 3'd2;
    localparam logic [2:0] ST_TX_RD    = 3'd3;
    localparam logic [2:0] ST_TX_LATCH = 3'd4;
    localparam logic [2:0] ST_TX_SEND  = 3'd5;
    localparam logic [2:0] ST_TX_WAIT  = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

endpackage

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
// Frame-level controller that owns a single shared memory port. A frame is:
// receive RX_BYTES bytes from the UART into memory, start the processing core
// and hand it the memory port until it signals completion, then read TX_BYTES
// bytes from TX_BASE and send them one at a time to the UART transmitter.
// After the last byte the sequencer parks in DONE until restart.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   rx_valid, rx_data        received-byte strobe and byte from the UART receiver
//   proc_start, proc_done    start pulse to the core, completion pulse from it
//   proc_mem_addr/we/wdata   core memory request, forwarded while processing
//   mem_addr/we/wdata/rdata  shared memory port (read data one cycle late)
//   tx_start, tx_data,       transmit handshake with the UART transmitter
//   tx_done
//   restart                  begin a new frame (honoured only in DONE)
//   Rx_finish, pro_over,     sticky phase-complete flags
//   Tx_finish
//   rx_overrun               sticky: a byte arrived while not receiving
// -----------------------------------------------------------------------------
module phase_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int RX_BYTES = 9,
    parameter int TX_BASE  = 0,
    parameter int TX_BYTES = 9
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,

    output logic              proc_start,
    input  logic              proc_done,
    input  logic [ADDR_W-1:0] proc_mem_addr,
    input  logic              proc_mem_we,
    input  logic [BYTE_W-1:0] proc_mem_wdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata,

    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_done,

    input  logic              restart,
    output logic              Rx_finish,
    output logic              pro_over,
    output logic              Tx_finish,
    output logic              rx_overrun
);

    localparam int RX_CW = (RX_BYTES > 1) ? $clog2(RX_BYTES) : 1;
    localparam int TX_CW = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;

    localparam logic [RX_CW-1:0]  RX_LAST      = RX_CW'(RX_BYTES - 1);
    localparam logic [TX_CW-1:0]  TX_LAST      = TX_CW'(TX_BYTES - 1);
    localparam logic [ADDR_W-1:0] TX_BASE_ADDR = ADDR_W'(TX_BASE);

    logic [STATE_W-1:0] state;
    logic [RX_CW-1:0]   rx_cnt;
    logic [TX_CW-1:0]   tx_cnt;

    // Frame sequencing. Each TX byte costs TX_RD (address out), TX_LATCH
    // (read data back) and TX_SEND (strobe), which fixes the gap between a
    // tx_done and the next tx_start at three cycles. Strobes from the core
    // or transmitter are only looked at in the state that expects them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RX;
            rx_cnt     <= '0;
            tx_cnt     <= '0;
            tx_data    <= '0;
            Rx_finish  <= 1'b0;
            pro_over   <= 1'b0;
            Tx_finish  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_valid && (state != ST_RX)) begin
                rx_overrun <= 1'b1;
            end

            case (state)
                ST_RX: begin
                    if (rx_valid) begin
                        rx_cnt <= rx_cnt + RX_CW'(1);
                        if (rx_cnt == RX_LAST) begin
                            Rx_finish <= 1'b1;
                            state     <= ST_PSTART;
                        end
                    end
                end
                ST_PSTART: begin
                    state <= ST_PROC;
                end
                ST_PROC: begin
                    if (proc_done) begin
                        pro_over <= 1'b1;
                        tx_cnt   <= '0;
                        state    <= ST_TX_RD;
                    end
                end
                ST_TX_RD: begin
                    state <= ST_TX_LATCH;
                end
                ST_TX_LATCH: begin
                    tx_data <= mem_rdata;
                    state   <= ST_TX_SEND;
                end
                ST_TX_SEND: begin
                    state <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (tx_done) begin
                        if (tx_cnt == TX_LAST) begin
                            Tx_finish <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            tx_cnt <= tx_cnt + TX_CW'(1);
                            state  <= ST_TX_RD;
                        end
                    end
                end
                ST_DONE: begin
                    // Placed after the overrun update so a restart clears
                    // the flag even if a stray byte arrives in the same cycle.
                    if (restart) begin
                        rx_cnt     <= '0;
                        tx_cnt     <= '0;
                        Rx_finish  <= 1'b0;
                        pro_over   <= 1'b0;
                        Tx_finish  <= 1'b0;
                        rx_overrun <= 1'b0;
                        state      <= ST_RX;
                    end
                end
                default: begin
                    state <= ST_RX;
                end
            endcase
        end
    end

    // Shared memory port owner, decoded from state. Write enables are held
    // off while rst is asserted so reset wins over a coincident byte or core
    // request. The TX address wraps naturally in ADDR_W bits.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            ST_RX: begin
                mem_addr  = ADDR_W'(rx_cnt);
                mem_we    = rx_valid && !rst;
                mem_wdata = rx_data;
            end
            ST_PROC: begin
                mem_addr  = proc_mem_addr;
                mem_we    = proc_mem_we && !rst;
                mem_wdata = proc_mem_wdata;
            end
            ST_TX_RD: begin
                mem_addr = TX_BASE_ADDR + ADDR_W'(tx_cnt);
            end
            default: begin
            end
        endcase
    end

    // Start strobes are pure state decodes, so each lasts exactly one cycle.
    assign proc_start = (state == ST_PSTART) && !rst;
    assign tx_start   = (state == ST_TX_SEND) && !rst;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
// Directed self-checking bench for phase_sequencer with default parameters.
// A behavioural byte memory with one-cycle read latency sits on the shared
// memory port. One frame is received, processed and transmitted, followed by
// restart and mid-frame reset checks.
// No ports (top-level bench).
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

    localparam int ADDR_W = 18;

    logic              clk;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              proc_start;
    logic              proc_done;
    logic [ADDR_W-1:0] proc_mem_addr;
    logic              proc_mem_we;
    logic [7:0]        proc_mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic              restart;
    logic              Rx_finish;
    logic              pro_over;
    logic              Tx_finish;
    logic              rx_overrun;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] rx_bytes [9];

    phase_sequencer #(
        .ADDR_W  (ADDR_W),
        .RX_BYTES(9),
        .TX_BASE (0),
        .TX_BYTES(9)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .proc_start    (proc_start),
        .proc_done     (proc_done),
        .proc_mem_addr (proc_mem_addr),
        .proc_mem_we   (proc_mem_we),
        .proc_mem_wdata(proc_mem_wdata),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_done       (tx_done),
        .restart       (restart),
        .Rx_finish     (Rx_finish),
        .pro_over      (pro_over),
        .Tx_finish     (Tx_finish),
        .rx_overrun    (rx_overrun)
    );

    // 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared memory: synchronous write, read data registered one cycle late.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Safety net so a stuck design can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change 1 unit after the rising edge; checks follow later in the
    // same cycle, well away from the next edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag,
                                input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_flags(input string tag,
                               input logic rxf, input logic pov,
                               input logic txf, input logic ovr);
        check_output({tag, " Rx_finish"},  32'(Rx_finish),  32'(rxf));
        check_output({tag, " pro_over"},   32'(pro_over),   32'(pov));
        check_output({tag, " Tx_finish"},  32'(Tx_finish),  32'(txf));
        check_output({tag, " rx_overrun"}, 32'(rx_overrun), 32'(ovr));
    endtask

    initial begin
        int gap;

        rx_bytes = '{8'd11, 8'd13, 8'd15, 8'd17, 8'd19,
                     8'd111, 8'd113, 8'd115, 8'd117};

        rst            = 1'b1;
        rx_valid       = 1'b0;
        rx_data        = 8'h00;
        proc_done      = 1'b0;
        proc_mem_addr  = '0;
        proc_mem_we    = 1'b0;
        proc_mem_wdata = 8'h00;
        tx_done        = 1'b0;
        restart        = 1'b0;

        // Reset state.
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        check_output("reset mem_we",     32'(mem_we),     32'd0);
        check_output("reset mem_addr",   32'(mem_addr),   32'd0);
        check_output("reset proc_start", 32'(proc_start), 32'd0);
        check_output("reset tx_start",   32'(tx_start),   32'd0);
        check_output("reset tx_data",    32'(tx_data),    32'd0);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // Strobes meant for other phases are ignored while receiving.
        next_cycle();
        proc_done = 1'b1;
        tx_done   = 1'b1;
        restart   = 1'b1;
        next_cycle();
        proc_done = 1'b0;
        tx_done   = 1'b0;
        restart   = 1'b0;
        #1;
        check_output("rx stray mem_addr", 32'(mem_addr), 32'd0);
        check_flags("rx stray", 1'b0, 1'b0, 1'b0, 1'b0);

        // Receive nine bytes; each is written at its index the same cycle.
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            rx_valid = 1'b1;
            rx_data  = rx_bytes[i];
            #1;
            check_output($sformatf("rx%0d mem_we", i),    32'(mem_we),    32'd1);
            check_output($sformatf("rx%0d mem_addr", i),  32'(mem_addr),  32'(i));
            check_output($sformatf("rx%0d mem_wdata", i), 32'(mem_wdata), 32'(rx_bytes[i]));
            check_output($sformatf("rx%0d Rx_finish", i), 32'(Rx_finish), 32'd0);
        end
        next_cycle();
        rx_valid = 1'b0;
        #1;
        check_output("pstart Rx_finish",  32'(Rx_finish),  32'd1);
        check_output("pstart proc_start", 32'(proc_start), 32'd1);
        check_output("pstart mem_we",     32'(mem_we),     32'd0);
        for (int i = 0; i < 9; i++) begin
            check_output($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(rx_bytes[i]));
        end

        // Processing: the core owns the port; restart here is ignored.
        next_cycle();
        check_output("proc proc_start", 32'(proc_start), 32'd0);
        proc_mem_addr  = 18'd5;
        proc_mem_we    = 1'b1;
        proc_mem_wdata = 8'hAA;
        restart        = 1'b1;
        #1;
        check_output("proc mem_addr",  32'(mem_addr),  32'd5);
        check_output("proc mem_we",    32'(mem_we),    32'd1);
        check_output("proc mem_wdata", 32'(mem_wdata), 32'hAA);
        // Withdraw the write before the edge so the frame data stays intact.
        #1;
        proc_mem_we = 1'b0;

        // A byte arriving mid-processing must not reach memory.
        next_cycle();
        restart  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        #1;
        check_output("overrun mem_we",    32'(mem_we),    32'd0);
        check_output("overrun mem_addr",  32'(mem_addr),  32'd5);
        check_output("overrun mem_wdata", 32'(mem_wdata), 32'hAA);
        next_cycle();
        rx_valid = 1'b0;
        #1;
        check_flags("after overrun", 1'b1, 1'b0, 1'b0, 1'b1);

        proc_done = 1'b1;
        next_cycle();
        proc_done = 1'b0;

        // Transmit nine bytes; tx_done returns 10 cycles after each tx_start.
        for (int k = 0; k < 9; k++) begin
            #1;
            check_output($sformatf("txrd%0d mem_addr", k), 32'(mem_addr), 32'(k));
            check_output($sformatf("txrd%0d mem_we", k),   32'(mem_we),   32'd0);
            check_output($sformatf("txrd%0d pro_over", k), 32'(pro_over), 32'd1);
            gap = 1;
            while (tx_start !== 1'b1 && gap < 20) begin
                next_cycle();
                gap++;
            end
            check_output($sformatf("tx%0d start gap", k), 32'(gap),       32'd3);
            check_output($sformatf("tx%0d tx_data", k),   32'(tx_data),   32'(rx_bytes[k]));
            check_output($sformatf("tx%0d Tx_finish", k), 32'(Tx_finish), 32'd0);
            if (k == 2) begin
                tx_done = 1'b1;
            end
            next_cycle();
            tx_done = 1'b0;
            check_output($sformatf("tx%0d start width", k), 32'(tx_start), 32'd0);
            repeat (9) next_cycle();
            tx_done = 1'b1;
            next_cycle();
            tx_done = 1'b0;
        end

        #1;
        check_output("done tx_start", 32'(tx_start), 32'd0);
        check_output("done mem_we",   32'(mem_we),   32'd0);
        check_output("done mem_addr", 32'(mem_addr), 32'd0);
        check_output("done tx_data",  32'(tx_data),  32'd117);
        check_flags("done", 1'b1, 1'b1, 1'b1, 1'b1);

        // Restart from DONE clears everything and returns to receive.
        restart = 1'b1;
        next_cycle();
        restart = 1'b0;
        #1;
        check_flags("restart", 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("restart mem_addr", 32'(mem_addr), 32'd0);

        // Reset after four bytes: receive restarts at address 0.
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(8'h21 + i);
            #1;
            check_output($sformatf("rx2 %0d mem_addr", i), 32'(mem_addr), 32'(i));
            check_output($sformatf("rx2 %0d mem_we", i),   32'(mem_we),   32'd1);
            next_cycle();
        end
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        #1;
        check_output("in reset mem_we", 32'(mem_we), 32'd0);
        next_cycle();
        rst      = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        #1;
        check_output("post reset mem_addr",  32'(mem_addr),  32'd0);
        check_output("post reset mem_we",    32'(mem_we),    32'd1);
        check_output("post reset mem_wdata", 32'(mem_wdata), 32'h5A);
        check_output("post reset tx_data",   32'(tx_data),   32'd0);
        check_flags("post reset", 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rx_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
